bus_reg_slave: RTL and testbench
================================

Name: bus_reg_slave

Overview:
Generic bus-slave responder for the shared system bus. It sits behind one chip-select output of the address decoder, for example a slave slot such as timer, UART or GPIO. It accepts address-strobed read/write requests from the bus master and answers with a one-cycle active-low ready plus read data. Behind the bus side is an 8-entry 32-bit register file that peripheral logic can also update through a hardware write port. It is the common slave-side template that peripherals instantiate.

Parameters:
WAIT_CYCLES, 0, wait states inserted between accepting a request and asserting rdy_; legal range 0..15.
ID_VALUE, 32'h0000_0000, constant returned by register 0, which is read-only.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous reset, active low
cs_  in  1  chip select from the address decoder, active low
as_  in  1  address strobe from the bus master, active low
rw  in  1  1 = read, 0 = write
addr  in  3  register index, taken from the low word-address bits
wr_data  in  32  write data
rd_data  out  32  read data; valid only while rdy_ = 0, otherwise 0
rdy_  out  1  ready, active low, exactly one cycle per accepted request
hw_we  in  1  hardware-side write enable, active high
hw_addr  in  3  hardware-side register index
hw_data  in  32  hardware-side write data
regs_out  out  256  flattened register file; reg i occupies bits [32*i+31:32*i]

Behaviour:
- Request acceptance: a request is accepted at a rising edge where cs_ = 0 and as_ = 0, and the FSM is in IDLE or RESP. On acceptance the block latches addr, rw and wr_data.
- States:
  - IDLE: waiting for a request.
  - WAIT: down-counter running.
  - RESP: rdy_ = 0 for this cycle.
- Transitions:
  - IDLE, request, WAIT_CYCLES = 0 -> RESP.
  - IDLE, request, WAIT_CYCLES > 0 -> WAIT, with counter loaded to WAIT_CYCLES - 1.
  - WAIT, counter != 0 -> stay in WAIT and decrement the counter.
  - WAIT, counter == 0 -> RESP.
  - RESP, new request -> same as the IDLE-with-request transitions (back-to-back accesses are supported).
  - RESP, no request -> IDLE.
- Latency: rdy_ is low in cycle k + 1 + WAIT_CYCLES, where k is the acceptance cycle. For WAIT_CYCLES = 0 this gives single-cycle response.
- Requests seen while in WAIT are ignored. The master must hold off until it has seen rdy_.
- rdy_ and rd_data are registered outputs; they are not combinational from the inputs.
- Read: rd_data = register[latched addr] as sampled at the edge entering RESP. rd_data is driven to 0 in every non-RESP cycle.
- Write: the register is updated at the edge entering RESP, i.e. the same edge that drives rdy_ low.
- Register 0 always reads ID_VALUE. Bus and hardware writes to register 0 are discarded, but the bus still receives rdy_.
- Hardware port: when hw_we = 1, register[hw_addr] is written at that edge, in any FSM state.
- Collision, same register: a bus write commit and hw_we to the same index at the same edge -> the bus value wins.
- Collision, different registers: both writes take effect.
- Read/hardware-write same edge: a bus read and hw_we to the same index -> the read returns the old value.
- Reset (asynchronous, any time, including mid-WAIT or in RESP):
  - FSM -> IDLE, counter -> 0.
  - rdy_ = 1, rd_data = 0.
  - Registers 1..7 = 0.
  - The pending request is dropped with no ready issued.
- After reset release, the first edge can accept a request.
- regs_out continuously reflects the register state, with reg 0 = ID_VALUE.

Test Plan:
- Reset: hold reset low, then release -> rdy_ = 1, rd_data = 0, regs 1..7 = 0, reg 0 = ID_VALUE = 32'hCAFE_0001.
- Single-cycle path, WAIT_CYCLES = 0:
  - Write 32'h1234_5678 to addr 3 -> rdy_ low for exactly one cycle, the cycle after the strobe; regs_out reg3 = 32'h1234_5678.
  - Then read addr 3 -> rd_data = 32'h1234_5678 during that rdy_ cycle and 0 otherwise.
- Wait states, WAIT_CYCLES = 3:
  - Read addr 0 -> rdy_ low in the 4th cycle after the strobe, rd_data = ID_VALUE.
  - A second strobe issued during WAIT is ignored: still exactly one rdy_ pulse.
- Back-to-back, WAIT_CYCLES = 0: strobes in consecutive cycles writing addr 1 = 5 then addr 2 = 9 -> two consecutive rdy_ pulses; reg1 = 5, reg2 = 9.
- Collisions:
  - Bus write addr 4 = 32'hAAAA_AAAA and hw_we addr 4 = 32'h5555_5555 at the commit edge -> reg4 = 32'hAAAA_AAAA.
  - Same-edge hw_we addr 5 with the bus write to addr 4 -> both registers updated.
  - Bus write to addr 0 -> rdy_ pulse issued, reg 0 unchanged.
- Mid-operation reset: WAIT_CYCLES = 5; assert reset during WAIT after a write to addr 6 -> no rdy_ pulse, reg6 = 0, FSM idle; the next request completes normally.

Source files
------------

// File: rtl/bus_reg_slave.sv
// Bus-slave responder: strobed read/write requests answered with a one-cycle
// active-low ready after WAIT_CYCLES wait states, backed by an 8x32 register file.
module bus_reg_slave #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs_,
  input  logic         as_,
  input  logic         rw,
  input  logic [2:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic         rdy_,
  input  logic         hw_we,
  input  logic [2:0]   hw_addr,
  input  logic [31:0]  hw_data,
  output logic [255:0] regs_out
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        addr_q;
  logic              rw_q;
  logic [31:0]       wdata_q;
  logic [7:1][31:0]  regs_q;
  logic [7:0][31:0]  reg_view;
  logic [31:0]       rd_data_q;
  logic              rdy_q;

  logic              accept;
  logic              enter_resp;
  logic [2:0]        cmt_addr;
  logic              cmt_rw;
  logic [31:0]       cmt_data;
  logic              bus_wr;

  assign accept = !cs_ && !as_ && (state_q != S_WAIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= 3'd0;
      rw_q    <= 1'b0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      addr_q  <= addr;
      rw_q    <= rw;
      wdata_q <= wr_data;
    end
  end

  // With no wait states the commit edge is the acceptance edge, so use the live request.
  assign cmt_addr = NO_WAIT ? addr    : addr_q;
  assign cmt_rw   = NO_WAIT ? rw      : rw_q;
  assign cmt_data = NO_WAIT ? wr_data : wdata_q;
  assign bus_wr   = enter_resp && !cmt_rw;

  // Bus commit takes priority over a hardware write to the same register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 1; i < 8; i++) begin
        if (bus_wr && cmt_addr == 3'(i)) begin
          regs_q[i] <= cmt_data;
        end else if (hw_we && hw_addr == 3'(i)) begin
          regs_q[i] <= hw_data;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_view
      if (gi == 0) begin : g_id
        assign reg_view[gi] = ID_VALUE;
      end else begin : g_reg
        assign reg_view[gi] = regs_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q     <= 1'b1;
      rd_data_q <= 32'd0;
    end else begin
      rdy_q     <= !enter_resp;
      rd_data_q <= (enter_resp && cmt_rw) ? reg_view[cmt_addr] : 32'd0;
    end
  end

  assign rdy_     = rdy_q;
  assign rd_data  = rd_data_q;
  assign regs_out = reg_view;

endmodule

// File: tb/tb_bus_reg_slave.sv
// Bench for bus_reg_slave: three instances (0, 3 and 5 wait states) share the
// bus wires and are selected by their own chip select.
module tb_bus_reg_slave;

  localparam logic [31:0] ID = 32'hCAFE_0001;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   cs_n;
  logic         as_n, rw;
  logic [2:0]   addr;
  logic [31:0]  wr_data;
  logic [2:0]   hw_we;
  logic [2:0]   hw_addr;
  logic [31:0]  hw_data;
  logic [2:0]   rdy;
  logic [31:0]  rd [3];
  logic [255:0] ro [3];

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [3][8];

  always #5 clk = ~clk;

  bus_reg_slave #(.WAIT_CYCLES(0), .ID_VALUE(ID)) u_d0 (
    .clk(clk), .reset(reset), .cs_(cs_n[0]), .as_(as_n), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd[0]), .rdy_(rdy[0]), .hw_we(hw_we[0]),
    .hw_addr(hw_addr), .hw_data(hw_data), .regs_out(ro[0]));
  bus_reg_slave #(.WAIT_CYCLES(3), .ID_VALUE(ID)) u_d3 (
    .clk(clk), .reset(reset), .cs_(cs_n[1]), .as_(as_n), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd[1]), .rdy_(rdy[1]), .hw_we(hw_we[1]),
    .hw_addr(hw_addr), .hw_data(hw_data), .regs_out(ro[1]));
  bus_reg_slave #(.WAIT_CYCLES(5), .ID_VALUE(ID)) u_d5 (
    .clk(clk), .reset(reset), .cs_(cs_n[2]), .as_(as_n), .rw(rw), .addr(addr),
    .wr_data(wr_data), .rd_data(rd[2]), .rdy_(rdy[2]), .hw_we(hw_we[2]),
    .hw_addr(hw_addr), .hw_data(hw_data), .regs_out(ro[2]));

  function automatic int wc(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 5;
  endfunction

  function automatic logic [255:0] model_vec(input int d);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = (i == 0) ? ID : mdl[d][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 8; i++) mdl[d][i] = 32'd0;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    cs_n = 3'b111; as_n = 1'b1; hw_we = 3'b000;
  endtask

  // One request to instance d; entered/left just after a rising edge.
  task automatic access(input int d, input bit rw_b, input logic [2:0] a, input logic [31:0] wd,
                        input bit hw_en, input logic [2:0] ha, input logic [31:0] hd,
                        input bit extra, output logic [31:0] got_rd);
    int w, pulses, pulse_at;
    bit strobe;
    logic [31:0] exp_rd;
    w = wc(d);
    exp_rd = (a == 3'd0) ? ID : mdl[d][a];
    pulses = 0; pulse_at = -1; got_rd = '0;
    for (int j = 0; j <= w + 2; j++) begin
      strobe  = (j == 0) || (extra && w > 0 && j == 1);
      cs_n[d] = !strobe;
      as_n    = !strobe;
      rw      = rw_b;
      addr    = (j == 0) ? a : a + 3'd1;
      wr_data = (j == 0) ? wd : ~wd;
      hw_we[d] = hw_en && (j == w);
      hw_addr  = ha;
      hw_data  = hd;
      @(posedge clk);
      if (j == w) begin
        if (hw_en && ha != 3'd0) mdl[d][ha] = hd;
        if (!rw_b && a != 3'd0) mdl[d][a] = wd;
      end
      #1;
      idle_bus();
      if (!rdy[d]) begin
        pulses++; pulse_at = j; got_rd = rd[d];
      end else begin
        chk("rd_idle_zero", 256'(rd[d]), 256'd0);
      end
    end
    $display("txn dut=%0d rw=%0b addr=%0d wd=%h hw=%0b/%0d/%h extra=%0b rd=%h",
             d, rw_b, a, wd, hw_en, ha, hd, extra, got_rd);
    chk("rdy_pulse_count", 256'(pulses), 256'd1);
    chk("rdy_latency", 256'(pulse_at), 256'(w));
    if (rw_b) chk("read_data", 256'(got_rd), 256'(exp_rd));
    chk("regs_out", ro[d], model_vec(d));
  endtask

  typedef struct {
    int          d;
    bit          rw;
    logic [2:0]  a;
    logic [31:0] wd;
    bit          hw;
    logic [2:0]  ha;
    logic [31:0] hd;
    bit          extra;
    logic [31:0] exp_rd;
    logic [2:0]  chk_a;
    logic [31:0] chk_v;
  } vec_t;

  initial begin
    vec_t tbl [9];
    logic [31:0] got;
    int pulses;

    tbl[0] = '{0, 1'b0, 3'd3, 32'h1234_5678, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 3'd3, 32'h1234_5678};
    tbl[1] = '{0, 1'b1, 3'd3, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 32'h1234_5678, 3'd3, 32'h1234_5678};
    tbl[2] = '{1, 1'b1, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, ID, 3'd0, ID};
    tbl[3] = '{0, 1'b0, 3'd4, 32'hAAAA_AAAA, 1'b1, 3'd4, 32'h5555_5555, 1'b0, 32'h0, 3'd4, 32'hAAAA_AAAA};
    tbl[4] = '{0, 1'b0, 3'd4, 32'h1111_2222, 1'b1, 3'd5, 32'h3333_4444, 1'b0, 32'h0, 3'd5, 32'h3333_4444};
    tbl[5] = '{0, 1'b0, 3'd0, 32'hDEAD_BEEF, 1'b1, 3'd0, 32'h0BAD_0BAD, 1'b0, 32'h0, 3'd0, ID};
    tbl[6] = '{1, 1'b0, 3'd2, 32'h0000_ABCD, 1'b0, 3'd0, 32'h0, 1'b1, 32'h0, 3'd2, 32'h0000_ABCD};
    tbl[7] = '{1, 1'b1, 3'd2, 32'h0, 1'b1, 3'd2, 32'h7777_7777, 1'b0, 32'h0000_ABCD, 3'd2, 32'h7777_7777};
    tbl[8] = '{2, 1'b0, 3'd6, 32'h0F0F_0F0F, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 3'd6, 32'h0F0F_0F0F};

    idle_bus();
    rw = 1'b0; addr = 3'd0; wr_data = 32'd0; hw_addr = 3'd0; hw_data = 32'd0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset_rdy", 256'(rdy[d]), 256'd1);
      chk("reset_rd", 256'(rd[d]), 256'd0);
      chk("reset_regs", ro[d], model_vec(d));
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 9; t++) begin
      access(tbl[t].d, tbl[t].rw, tbl[t].a, tbl[t].wd, tbl[t].hw, tbl[t].ha, tbl[t].hd,
             tbl[t].extra, got);
      if (tbl[t].rw) chk("tbl_read", 256'(got), 256'(tbl[t].exp_rd));
      chk("tbl_reg", 256'(ro[tbl[t].d][32*tbl[t].chk_a +: 32]), 256'(tbl[t].chk_v));
    end

    // Back-to-back writes on the zero-wait instance.
    cs_n[0] = 1'b0; as_n = 1'b0; rw = 1'b0; addr = 3'd1; wr_data = 32'd5;
    @(posedge clk); mdl[0][1] = 32'd5; #1;
    addr = 3'd2; wr_data = 32'd9;
    chk("b2b_rdy1", 256'(rdy[0]), 256'd0);
    @(posedge clk); mdl[0][2] = 32'd9; #1;
    idle_bus();
    chk("b2b_rdy2", 256'(rdy[0]), 256'd0);
    @(posedge clk); #1;
    chk("b2b_rdy_end", 256'(rdy[0]), 256'd1);
    chk("b2b_regs", ro[0], model_vec(0));
    $display("txn b2b dut=0 reg1=%h reg2=%h", ro[0][63:32], ro[0][95:64]);

    // Reset in the middle of a wait phase on the five-wait instance.
    cs_n[2] = 1'b0; as_n = 1'b0; rw = 1'b0; addr = 3'd6; wr_data = 32'h6666_0006;
    @(posedge clk); #1;
    idle_bus();
    pulses = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (!rdy[2]) pulses++;
    end
    #2 reset = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      chk("midrst_rdy", 256'(rdy[d]), 256'd1);
      chk("midrst_regs", ro[d], model_vec(d));
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      if (!rdy[2]) pulses++;
    end
    chk("midrst_no_pulse", 256'(pulses), 256'd0);
    $display("txn midreset dut=2 reg6=%h pulses=%0d", ro[2][223:192], pulses);
    access(2, 1'b1, 3'd6, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, got);
    access(2, 1'b0, 3'd6, 32'h0600_0060, 1'b0, 3'd0, 32'h0, 1'b0, got);

    // Random traffic against the register-file model.
    for (int n = 0; n < 80; n++) begin
      access($urandom_range(0, 2), 1'($urandom), 3'($urandom), $urandom,
             1'($urandom), 3'($urandom), $urandom, 1'($urandom), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
